instruction_fetch_stage: RTL and testbench

Fetch stage of the single-issue MIPS pipeline. Owns the program counter and drives the combinational-read instruction memory with the word-aligned PC. Captures the returned instruction together with PC+4 into the IF/ID pipeline register for the decode stage. Supports pipeline stall, IF/ID flush (bubble insertion) and PC redirect from branch/jump resolution.

---
 rtl/instruction_fetch_stage.sv | 65 ++++++
 tb/tb_instruction_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// captures the fetched word with PC+4 into the IF/ID register.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
);

    // Only the word index is stored, so the PC cannot become misaligned.
    logic [29:0] pc_word;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [29:0] pc_word_next;

    assign pc          = {pc_word, 2'b00};
    assign pc_plus4    = pc + 32'd4;
    assign IMemAddress = pc;

    // Redirect outranks stall so a resolved branch is never dropped.
    always_comb begin
        pc_word_next = pc_plus4[31:2];
        if (RedirectValid) begin
            pc_word_next = RedirectTarget[31:2];
        end else if (Stall) begin
            pc_word_next = pc_word;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_word <= RESET_PC[31:2];
        end else begin
            pc_word <= pc_word_next;
        end
    end

    // Flush outranks stall so a bubble can replace a held instruction.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IFID_Instruction <= NOP_WORD;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else if (Flush) begin
            IFID_Instruction <= NOP_WORD;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else if (!Stall) begin
            IFID_Instruction <= IMemInstruction;
            IFID_PCPlus4     <= pc_plus4;
            IFID_Valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: a reference model pushes the expected
// PC and IF/ID state per edge into a queue that is popped after each edge.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic [31:0] IMemAddress;
    logic [31:0] IMemInstruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    logic [31:0] w_addr;
    logic [31:0] w_instr_in;
    logic [31:0] w_instr;
    logic [31:0] w_pcp4;
    logic        w_valid;

    int checks = 0;
    int failures = 0;

    // {valid, instruction, pc_plus4, pc}
    logic [96:0] exp_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {25'd0, addr[8:2]};
        return idx * 32'd3;
    endfunction

    assign IMemInstruction = mem_word(IMemAddress);
    assign w_instr_in      = mem_word(w_addr);

    instruction_fetch_stage dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
        .IMemAddress(IMemAddress), .IMemInstruction(IMemInstruction),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
        .IMemAddress(w_addr), .IMemInstruction(w_instr_in),
        .IFID_Instruction(w_instr), .IFID_PCPlus4(w_pcp4),
        .IFID_Valid(w_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_instr = NOP;
        m_pcp4  = 32'd0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] tgt);
        logic [31:0] n_pc, n_instr, n_pcp4, p4;
        logic        n_valid;
        logic [96:0] e;
        Stall = s; Flush = f; RedirectValid = rv; RedirectTarget = tgt;
        p4 = m_pc + 32'd4;
        if (rv)     n_pc = {tgt[31:2], 2'b00};
        else if (s) n_pc = m_pc;
        else        n_pc = p4;
        if (f) begin
            n_instr = NOP; n_pcp4 = 32'd0; n_valid = 1'b0;
        end else if (s) begin
            n_instr = m_instr; n_pcp4 = m_pcp4; n_valid = m_valid;
        end else begin
            n_instr = mem_word(m_pc); n_pcp4 = p4; n_valid = 1'b1;
        end
        exp_q.push_back({n_valid, n_instr, n_pcp4, n_pc});
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        check("pc",      IMemAddress,         e[31:0]);
        check("pcplus4", IFID_PCPlus4,        e[63:32]);
        check("instr",   IFID_Instruction,    e[95:64]);
        check("valid",   {31'd0, IFID_Valid}, {31'd0, e[96]});
        m_pc = e[31:0]; m_pcp4 = e[63:32]; m_instr = e[95:64]; m_valid = e[96];
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},      IMemAddress,         32'h0000_0000);
        check({tag, "_instr"},   IFID_Instruction,    NOP);
        check({tag, "_pcplus4"}, IFID_PCPlus4,        32'd0);
        check({tag, "_valid"},   {31'd0, IFID_Valid}, 32'd0);
        check({tag, "_wrap_pc"}, w_addr,              32'hFFFF_FFFC);
    endtask

    // Reset asserted between edges; outputs must react without a clock.
    task automatic async_reset(input string tag);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        RedirectValid = 1'b0; RedirectTarget = 32'd0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // Free-running fetch; the wrap instance is checked on the first edge.
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("first_instr", IFID_Instruction, 32'd0);
        check("first_pcp4",  IFID_PCPlus4,     32'd4);
        check("wrap_pcp4",   w_pcp4,           32'd0);
        check("wrap_pc",     w_addr,           32'd0);
        check("wrap_instr",  w_instr,          32'd381);
        check("wrap_valid",  {31'd0, w_valid}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check("run4_pc",    IMemAddress,      32'd16);
        check("run4_instr", IFID_Instruction, 32'd9);

        // Restart mid-stream, advance to PC=8, then stall three cycles.
        async_reset("midreset");
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("stall_pc",    IMemAddress,      32'd8);
        check("stall_instr", IFID_Instruction, 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("release_instr", IFID_Instruction, 32'd6);
        check("release_pcp4",  IFID_PCPlus4,     32'd12);

        // Taken branch without delay slot, unaligned target.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
        check("redir_pc",    IMemAddress,         32'h40);
        check("redir_valid", {31'd0, IFID_Valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("target_instr", IFID_Instruction, 32'd48);
        check("target_pcp4",  IFID_PCPlus4,     32'h44);

        // Redirect during stall, then stall with flush.
        step(1'b1, 1'b0, 1'b1, 32'h0000_0020);
        check("stall_redir_pc",    IMemAddress,      32'h20);
        check("stall_redir_instr", IFID_Instruction, 32'd48);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("stall_flush_valid", {31'd0, IFID_Valid}, 32'd0);
        check("stall_flush_pc",    IMemAddress,         32'h20);

        // Random mix of control inputs.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 5) == 0), $urandom);
        end

        async_reset("endreset");
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("restart_pcp4", IFID_PCPlus4, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
